// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: turns the UART byte stream into pixel writes.
// Frame layout: SYNC, ADDR_HI, ADDR_LO, COUNT, COUNT*3 data bytes, CHECK.
// Each complete RGB triplet becomes one write strobe.
// A good frame ends with a frame_done pulse.
// A bad checksum or an inter-byte timeout ends with a frame_error pulse.
module uart_frame_decoder #(
    parameter int          LED_COUNT      = 256,
    parameter int          TIMEOUT_CYCLES = 12000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clock_12mhz,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_ready,
    output logic        perform_write,
    output logic [8:0]  write_address,
    output logic [23:0] write_data,
    output logic        frame_done,
    output logic        frame_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_COUNT,
        S_DATA,
        S_CHECK
    } state_t;

    localparam int               TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]       LED_LIMIT    = 10'(LED_COUNT);

    state_t          state_reg;
    logic [1:0]      ready_sync_reg;
    logic            ready_prev_reg;
    logic [TW-1:0]   timeout_count_reg;
    logic [7:0]      checksum_reg;
    logic [8:0]      base_reg;
    logic [7:0]      count_reg;
    logic [7:0]      pixel_index_reg;
    logic [1:0]      phase_reg;
    logic [7:0]      b0_reg;
    logic [7:0]      b1_reg;

    logic            accept;
    logic            timeout_hit;
    logic            last_pixel;
    logic [8:0]      pixel_addr;

    // One byte per rising edge of the synchronized ready level.
    assign accept      = ready_sync_reg[1] & ~ready_prev_reg;
    // The counter reaches TIMEOUT_CYCLES on this edge. A byte arriving in the same cycle wins.
    assign timeout_hit = (state_reg != S_IDLE) && (timeout_count_reg == TIMEOUT_LAST) && !accept;
    // COUNT of 0 means 256 pixels; the 8-bit subtraction wraps to 255 for that case.
    assign last_pixel  = (pixel_index_reg == count_reg - 8'd1);
    // The 9-bit sum wraps naturally from 511 to 0.
    assign pixel_addr  = base_reg + {1'b0, pixel_index_reg};

    // Bring rx_data_ready (from the UART's slower clock) into this domain and keep the previous level for edge detection.
    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            ready_sync_reg <= 2'b00;
            ready_prev_reg <= 1'b0;
        end else begin
            ready_sync_reg <= {ready_sync_reg[0], rx_data_ready};
            ready_prev_reg <= ready_sync_reg[1];
        end
    end

    // Frame parser FSM with registered strobes, the running checksum and the inter-byte timeout.
    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            busy              <= 1'b0;
            perform_write     <= 1'b0;
            write_address     <= '0;
            write_data        <= '0;
            frame_done        <= 1'b0;
            frame_error       <= 1'b0;
            timeout_count_reg <= '0;
            checksum_reg      <= '0;
            base_reg          <= '0;
            count_reg         <= '0;
            pixel_index_reg   <= '0;
            phase_reg         <= '0;
            b0_reg            <= '0;
            b1_reg            <= '0;
        end else begin
            perform_write <= 1'b0;
            frame_done    <= 1'b0;
            frame_error   <= 1'b0;

            if (accept || state_reg == S_IDLE) begin
                timeout_count_reg <= '0;
            end else begin
                timeout_count_reg <= timeout_count_reg + 1'b1;
            end

            if (timeout_hit) begin
                // Abandon the frame; any partially collected pixel bytes are discarded.
                state_reg         <= S_IDLE;
                busy              <= 1'b0;
                frame_error       <= 1'b1;
                phase_reg         <= '0;
                timeout_count_reg <= '0;
            end else if (accept) begin
                case (state_reg)
                    S_IDLE: begin
                        checksum_reg <= '0;
                        if (rx_data == SYNC_BYTE) begin
                            state_reg <= S_ADDR_HI;
                            busy      <= 1'b1;
                        end
                    end
                    S_ADDR_HI: begin
                        base_reg[8]  <= rx_data[0];
                        checksum_reg <= checksum_reg ^ rx_data;
                        state_reg    <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        base_reg[7:0] <= rx_data;
                        checksum_reg  <= checksum_reg ^ rx_data;
                        state_reg     <= S_COUNT;
                    end
                    S_COUNT: begin
                        count_reg       <= rx_data;
                        pixel_index_reg <= '0;
                        phase_reg       <= '0;
                        checksum_reg    <= checksum_reg ^ rx_data;
                        state_reg       <= S_DATA;
                    end
                    S_DATA: begin
                        checksum_reg <= checksum_reg ^ rx_data;
                        case (phase_reg)
                            2'd0: begin
                                b0_reg    <= rx_data;
                                phase_reg <= 2'd1;
                            end
                            2'd1: begin
                                b1_reg    <= rx_data;
                                phase_reg <= 2'd2;
                            end
                            default: begin
                                phase_reg <= 2'd0;
                                // Out-of-range pixels are dropped, but the frame keeps parsing.
                                if ({1'b0, pixel_addr} < LED_LIMIT) begin
                                    perform_write <= 1'b1;
                                    write_address <= pixel_addr;
                                    write_data    <= {b0_reg, b1_reg, rx_data};
                                end
                                if (last_pixel) begin
                                    state_reg <= S_CHECK;
                                end else begin
                                    pixel_index_reg <= pixel_index_reg + 8'd1;
                                end
                            end
                        endcase
                    end
                    S_CHECK: begin
                        if (rx_data == checksum_reg) begin
                            frame_done <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Testbench for uart_frame_decoder.
// A frame-level model predicts the write strobes and the done/error events.
// A monitor compares every strobe and pulse against that prediction.
module tb_uart_frame_decoder;

    localparam int LED_COUNT = 256;
    localparam int TIMEOUT   = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_data_ready;
    logic        perform_write;
    logic [8:0]  write_address;
    logic [23:0] write_data;
    logic        frame_done;
    logic        frame_error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_e_cyc  = 0;
    int error_cyc   = -1;

    logic [32:0] exp_writes[$];   // {address, data}
    int          exp_events[$];   // 1 = done, 2 = error
    logic [7:0]  frame_data[$];

    uart_frame_decoder #(
        .LED_COUNT      (LED_COUNT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clock_12mhz   (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .perform_write (perform_write),
        .write_address (write_address),
        .write_data    (write_data),
        .frame_done    (frame_done),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every strobe and pulse against the predicted sequence.
    always @(negedge clk) begin
        logic [32:0] w;
        int          ev;
        if (!reset) begin
            if (perform_write) begin
                if (exp_writes.size() == 0) begin
                    check("unexpected_write", {write_address, write_data}, 0);
                end else begin
                    w = exp_writes.pop_front();
                    check("write_addr", write_address, w[32:24]);
                    check("write_data", write_data, w[23:0]);
                end
            end
            if (frame_done || frame_error) begin
                if (frame_error) error_cyc = cyc;
                if (exp_events.size() == 0) begin
                    check("unexpected_event", {frame_done, frame_error}, 0);
                end else begin
                    ev = exp_events.pop_front();
                    check("event_kind", {frame_done, frame_error}, (ev == 1) ? 2'b10 : 2'b01);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data       = b;
        rx_data_ready = 1'b1;
        last_e_cyc    = cyc + 3;
        repeat (4) @(negedge clk);
        rx_data_ready = 1'b0;
        repeat ($urandom_range(3, 12)) @(negedge clk);
    endtask

    // Send one frame (optionally truncated after stop_after bytes) and predict its effects.
    task automatic send_frame(input int base, input int npix, input bit corrupt, input int stop_after);
        logic [7:0] bytes[$];
        logic [7:0] chk;
        int         addr;
        int         p;
        if (frame_data.size() != npix * 3) begin
            frame_data.delete();
            for (int i = 0; i < npix * 3; i++) frame_data.push_back(8'($urandom));
        end
        bytes.push_back(8'hA5);
        bytes.push_back(8'(($urandom_range(0, 127) << 1) | ((base >> 8) & 1)));
        bytes.push_back(8'(base & 255));
        bytes.push_back(8'(npix & 255));
        for (int i = 0; i < npix * 3; i++) bytes.push_back(frame_data[i]);
        chk = 8'h00;
        for (int i = 1; i < bytes.size(); i++) chk = chk ^ bytes[i];
        if (corrupt) chk = chk ^ 8'(1 << $urandom_range(0, 7));
        bytes.push_back(chk);
        $display("frame base=%0d pixels=%0d corrupt=%0d stop=%0d chk=%02h", base, npix, corrupt, stop_after, chk);
        for (int j = 0; j < bytes.size(); j++) begin
            if (stop_after >= 0 && j >= stop_after) break;
            if (j >= 4 && j < bytes.size() - 1 && ((j - 4) % 3) == 2) begin
                p    = (j - 4) / 3;
                addr = (base + p) % 512;
                if (addr < LED_COUNT)
                    exp_writes.push_back({9'(addr), frame_data[j-6], frame_data[j-5], frame_data[j-4]});
            end
            if (j == bytes.size() - 1) exp_events.push_back(corrupt ? 2 : 1);
            send_byte(bytes[j]);
            if (j == 1) check("busy_in_frame", busy, 1);
        end
        frame_data.delete();
    endtask

    task automatic settle(input string tag);
        repeat (10) @(negedge clk);
        check({tag, "_pending_writes"}, exp_writes.size(), 0);
        check({tag, "_pending_events"}, exp_events.size(), 0);
        check({tag, "_busy_idle"}, busy, 0);
        exp_writes.delete();
        exp_events.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] g;
        reset         = 1'b1;
        rx_data       = 8'h00;
        rx_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_perform_write", perform_write, 0);
        check("rst_write_address", write_address, 0);
        check("rst_write_data", write_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single pixel at address 5, good checksum.
        frame_data = '{8'h11, 8'h22, 8'h33};
        send_frame(5, 1, 1'b0, -1);
        settle("basic");
        check("hold_address", write_address, 9'd5);
        check("hold_data", write_data, 24'h112233);

        // Crossing the LED_COUNT boundary: 256 is suppressed.
        send_frame(254, 3, 1'b0, -1);
        settle("boundary");

        // Bad checksum: write still happens, error reported.
        frame_data = '{8'h11, 8'h22, 8'h33};
        send_frame(5, 1, 1'b1, -1);
        settle("bad_chk");

        // Garbage ahead of a valid frame.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        check("garbage_busy", busy, 0);
        frame_data = '{8'h11, 8'h22, 8'h33};
        send_frame(5, 1, 1'b0, -1);
        settle("garbage");

        // Timeout after the first data byte.
        frame_data = '{8'h11, 8'h22, 8'h33};
        error_cyc  = -1;
        send_frame(5, 1, 1'b0, 5);
        exp_events.push_back(2);
        repeat (TIMEOUT + 20) @(negedge clk);
        check("timeout_cycle", error_cyc, last_e_cyc + TIMEOUT);
        settle("timeout");
        send_frame(37, 2, 1'b0, -1);
        settle("after_timeout");

        // COUNT = 0 means 256 pixels, wrapping past 511.
        send_frame(400, 256, 1'b0, -1);
        settle("count256");

        // Reset in the middle of the data bytes: silent discard.
        send_frame(120, 256, 1'b0, 104);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_perform_write", perform_write, 0);
        check("midrst_write_address", write_address, 0);
        check("midrst_write_data", write_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_events", {frame_done, frame_error}, 0);
        reset = 1'b0;
        repeat (TIMEOUT + 20) @(negedge clk);
        settle("midrst");

        // Randomized frames with garbage prefixes and occasional bad checksums.
        for (int n = 0; n < 25; n++) begin
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g);
            end
            send_frame($urandom_range(0, 511), $urandom_range(1, 6), ($urandom_range(0, 3) == 0), -1);
            settle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
